// File: rtl/hall_emulator_if.sv
// hall_emulator_if: control inputs and sensor outputs of the Hall-sensor emulator
interface hall_emulator_if #(
   parameter int PERIOD_WIDTH = 32,
   parameter int PULSE_WIDTH  = 16
);
   logic                    enable;
   logic [PERIOD_WIDTH-1:0] half_turn_cycles;
   logic [PULSE_WIDTH-1:0]  pulse_cycles;
   logic [PERIOD_WIDTH-1:0] ramp_step;
   logic                    hall_1;
   logic                    hall_2;
   logic                    half_turn_start;
   logic                    running;
   logic [PERIOD_WIDTH-1:0] cur_period;
   modport master (
      output enable, half_turn_cycles, pulse_cycles, ramp_step,
      input  hall_1, hall_2, half_turn_start, running, cur_period
   );
   modport slave (
      input  enable, half_turn_cycles, pulse_cycles, ramp_step,
      output hall_1, hall_2, half_turn_start, running, cur_period
   );
endinterface

// File: rtl/hall_emulator.sv
// hall_emulator: generates alternating active-low Hall pulses at a programmable, optionally ramped half-turn period
module hall_emulator #(
   parameter int                    PERIOD_WIDTH = 32,
   parameter int                    PULSE_WIDTH  = 16,
   parameter logic [PERIOD_WIDTH-1:0] START_PERIOD = 32'd50_000_000
) (
   input logic            clk,
   input logic            nrst,
   hall_emulator_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
   state_t                  state, state_n;
   logic [PERIOD_WIDTH-1:0] cnt, cnt_n, p, p_n, floor_p, diff, delta, raw;
   logic [PULSE_WIDTH-1:0]  w, w_n, w_in;
   logic                    sel, sel_n, up, wrap, start;
   // next half-turn parameters, ramp arithmetic and state transitions
   always_comb begin
      w_in    = (bus.pulse_cycles == '0) ? PULSE_WIDTH'(1) : bus.pulse_cycles;
      floor_p = PERIOD_WIDTH'(w_in) + PERIOD_WIDTH'(2);
      up      = bus.half_turn_cycles > p;
      diff    = up ? bus.half_turn_cycles - p : p - bus.half_turn_cycles;
      delta   = (bus.ramp_step < diff) ? bus.ramp_step : diff;
      raw     = (bus.ramp_step == '0) ? bus.half_turn_cycles :
                (state == IDLE) ? START_PERIOD : up ? p + delta : p - delta;
      wrap    = (state == GAP) && bus.enable && (cnt == p - PERIOD_WIDTH'(1));
      start   = ((state == IDLE) && bus.enable) || wrap;
      state_n = state;
      cnt_n   = cnt + PERIOD_WIDTH'(1);
      sel_n   = sel;
      w_n     = w;
      p_n     = p;
      if (start) begin
         state_n = PULSE;
         cnt_n   = '0;
         sel_n   = wrap ? ~sel : 1'b0;
         w_n     = w_in;
         p_n     = (raw < floor_p) ? floor_p : raw;
      end else if ((state == IDLE) || ((state == GAP) && !bus.enable)) begin
         state_n = IDLE;
         cnt_n   = '0;
         sel_n   = 1'b0;
      end else if ((state == PULSE) && (cnt == PERIOD_WIDTH'(w) - PERIOD_WIDTH'(1))) begin
         state_n = GAP;
      end
   end
   // FSM, phase counter and latched half-turn parameters
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         cnt   <= '0;
         sel   <= 1'b0;
         w     <= '0;
         p     <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sel   <= sel_n;
         w     <= w_n;
         p     <= p_n;
      end
   end
   // registered outputs; the line is low for exactly the cycles spent in PULSE
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         bus.hall_1          <= 1'b1;
         bus.hall_2          <= 1'b1;
         bus.half_turn_start <= 1'b0;
         bus.running         <= 1'b0;
         bus.cur_period      <= '0;
      end else begin
         bus.hall_1          <= !((state == PULSE) && !sel);
         bus.hall_2          <= !((state == PULSE) && sel);
         bus.half_turn_start <= (state == PULSE) && (cnt == '0);
         bus.running         <= state != IDLE;
         bus.cur_period      <= p;
      end
   end
endmodule

// File: doc/hall_emulator.md
# hall_emulator

Generates the two active-low Hall-sensor waveforms (`hall_1`, `hall_2`) of a rotating display at a programmable, optionally ramped, half-turn period. It sits in place of the physical sensors for bench, demo and no-motor operation. It drives the Hall-sensor decoder inputs so that slice counting and `position_sync` generation can run without a spinning rotor. Each half-turn produces exactly one low pulse, alternating between `hall_1` and `hall_2`. Both lines stay high between pulses, as the decoder's guard logic requires.

## Interface
- `PERIOD_WIDTH`, 32: width of the period and counter datapath.
- `PULSE_WIDTH`, 16: width of the pulse-length input.
- `START_PERIOD`, 32'd50_000_000: initial half-turn period (cycles) on spin-up when ramping is enabled.

- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; high runs the emulated rotor, low stops it.
- `half_turn_cycles`  in  PERIOD_WIDTH  target half-turn period in cycles.
- `pulse_cycles`  in  PULSE_WIDTH  sensor low time in cycles.
- `ramp_step`  in  PERIOD_WIDTH  maximum period change per half-turn; 0 means jump directly to the target.
- `hall_1`  out  1  emulated sensor 1, active low.
- `hall_2`  out  1  emulated sensor 2, active low.
- `half_turn_start`  out  1  1-cycle pulse on the first low cycle of each sensor pulse.
- `running`  out  1  high whenever the FSM is not in IDLE.
- `cur_period`  out  PERIOD_WIDTH  effective half-turn period currently in use.

## Operation
- FSM states: IDLE, PULSE, GAP. A phase counter `cnt` (PERIOD_WIDTH) and a sensor-select bit `sel` (0 selects `hall_1`, 1 selects `hall_2`) run alongside it.
- All outputs are registered.
- **IDLE**
  - Both sensor lines are high; `cnt`=0; `sel`=0.
  - `enable`=1 starts a half-turn with `sel`=0.
- **Half-turn start** (entry from IDLE, or wrap from GAP):
  - `half_turn_cycles`, `pulse_cycles` and `ramp_step` are latched.
  - `cur_period` is updated.
  - `cnt` is set to 0, the selected line goes low, and `half_turn_start` is 1.
- **Period update**
  - From IDLE: `cur_period` is the target if `ramp_step`=0, otherwise `START_PERIOD`.
  - On a wrap: `cur_period` moves toward the target by min(`ramp_step`, |target − `cur_period`|). If `ramp_step`=0, it is set equal to the target.
- **Clamping**
  - Effective width W = max(`pulse_cycles`, 1).
  - Effective period P = max(`cur_period`, W+2), so each pulse is followed by at least 2 all-high cycles.
  - `cur_period` reports P.
- **PULSE**
  - The selected line is low while `cnt` < W; `cnt` increments every cycle.
  - `enable` is ignored, so a pulse is never truncated.
  - At `cnt`=W−1 the FSM moves to GAP and the line goes high.
- **GAP**
  - Both lines are high.
  - If `enable`=0, the FSM goes to IDLE next cycle.
  - Otherwise, at `cnt`=P−1 it wraps: `sel` toggles and a new half-turn starts.
- Re-enabling after a stop always restarts with `hall_1`, and from `START_PERIOD` when ramping.
- The ramp arithmetic is unsigned and saturates at the target. It never overshoots.

## Timing
- **Reset values:** `hall_1`=1, `hall_2`=1, `half_turn_start`=0, `running`=0, `cur_period`=0, state IDLE.
- **Reset mid-pulse:** both lines return high immediately (asynchronously).
- **Start latency:** `enable` sampled high in IDLE at edge k gives the line low, `half_turn_start`=1 and `running`=1 after edge k+1.
- **Period:** consecutive `half_turn_start` pulses are exactly P cycles apart, where P is the value latched at the earlier start.
- **Stop latency:**
  - `enable` sampled low in GAP gives `running`=0 one cycle later.
  - In PULSE, the stop takes effect W−`cnt` cycles later, plus one cycle.
- **Never allowed:**
  - `hall_1` and `hall_2` low simultaneously.
  - A pulse shorter than W cycles.
- **Mid-half-turn input changes** take effect only at the next half-turn start.

## Test plan
- **Basic run:** reset, then `half_turn_cycles`=100, `pulse_cycles`=10, `ramp_step`=0, `enable`=1.
  - `hall_1` is low for 10 cycles, then high for 90.
  - `hall_2` is then low for 10 cycles, alternating thereafter.
  - `half_turn_start` occurs every 100 cycles and `cur_period`=100.
- **Clamping:** `half_turn_cycles`=5, `pulse_cycles`=8 gives P=10 and W=8. `pulse_cycles`=0 gives W=1.
- **Ramp:** `START_PERIOD`=1000, target=700, `ramp_step`=100.
  - Successive half-turn periods are 1000, 900, 800, 700, 700.
  - Then target=750 gives 750 with no overshoot.
- **Stop mid-pulse:** drop `enable` at `cnt`=3 with W=10.
  - The line stays low until `cnt`=9 and goes high.
  - `running` falls 1 cycle later.
  - The restart begins on `hall_1`.
- **Async reset:** assert `nrst` low during a `hall_2` pulse.
  - Both lines go high at once and `running`=0.
  - After release the block stays idle until `enable` is sampled high.
- **Loopback with the decoder:** P=1280, W=50.
  - `slice_cnt` resets on each pulse.
  - From the second half-turn on, `position_sync` occurs every 10 cycles, 128 slices per half-turn.
